// File: rtl/dmem_sig_uart.sv
// Snoops dmem writes: signature words go through a FIFO out an 8N1 UART as ASCII hex + CR/LF.
// A halt write raises the sticky halt_done once the FIFO and transmitter have drained.
module dmem_sig_uart #(
  parameter logic [31:0] SIG_ADDR     = 32'hF0000004,
  parameter logic [31:0] HALT_ADDR    = 32'hCAFECAFE,
  parameter logic [31:0] HALT_DATA    = 32'hF0000000,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          CLKS_PER_BIT = 4
) (
  input  logic                          sysclk,
  input  logic                          rst_in,
  input  logic                          dmem_wr_en,
  input  logic [31:0]                   dmem_wr_addr,
  input  logic [31:0]                   dmem_wr_data,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          halt_done
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  logic [31:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [1:0]        state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [3:0]        char_idx;
  logic [31:0]       word_reg;
  logic              halt_pending;
  logic [3:0]        nibble;
  logic [7:0]        cur_char;

  logic sig_hit;
  logic halt_hit;
  logic push;
  logic pop;
  logic baud_last;

  assign sig_hit   = dmem_wr_en && (dmem_wr_addr == SIG_ADDR);
  assign halt_hit  = dmem_wr_en && (dmem_wr_addr == HALT_ADDR) && (dmem_wr_data == HALT_DATA);
  // Fullness is judged on the pre-edge count, so a same-edge pop never rescues a push into a full FIFO.
  assign push      = sig_hit && (fifo_count < CNT_FULL);
  assign pop       = (state == ST_IDLE) && (fifo_count != '0);
  assign baud_last = (baud_cnt == BAUD_LAST);
  assign tx_busy   = (state != ST_IDLE);

  always_ff @(posedge sysclk) begin
    if (push) mem[wr_ptr] <= dmem_wr_data;
  end

  always_ff @(posedge sysclk) begin
    if (rst_in) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (sig_hit && !push) overflow <= 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst_in) begin
      halt_pending <= 1'b0;
      halt_done    <= 1'b0;
    end else begin
      if (halt_hit) halt_pending <= 1'b1;
      if (halt_pending && (fifo_count == '0) && (state == ST_IDLE)) halt_done <= 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst_in) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      char_idx <= '0;
      word_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            word_reg <= mem[rd_ptr];
            char_idx <= 4'd0;
            bit_idx  <= 3'd0;
            baud_cnt <= '0;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        ST_DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) state <= ST_STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        ST_STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (char_idx == 4'd9) begin
              state <= ST_IDLE;
            end else begin
              char_idx <= char_idx + 4'd1;
              state    <= ST_START;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Chars 0-7 are the word's nibbles MSB-first in lowercase hex, 8 is CR, 9 is LF.
  always_comb begin
    nibble = 4'h0;
    case (char_idx[2:0])
      3'd0: nibble = word_reg[31:28];
      3'd1: nibble = word_reg[27:24];
      3'd2: nibble = word_reg[23:20];
      3'd3: nibble = word_reg[19:16];
      3'd4: nibble = word_reg[15:12];
      3'd5: nibble = word_reg[11:8];
      3'd6: nibble = word_reg[7:4];
      default: nibble = word_reg[3:0];
    endcase
    if (char_idx == 4'd8)      cur_char = 8'h0D;
    else if (char_idx == 4'd9) cur_char = 8'h0A;
    else if (nibble < 4'd10)   cur_char = 8'h30 + {4'h0, nibble};
    else                       cur_char = 8'h57 + {4'h0, nibble};
  end

  always_comb begin
    uart_tx = 1'b1;
    case (state)
      ST_START: uart_tx = 1'b0;
      ST_DATA:  uart_tx = cur_char[bit_idx];
      default:  uart_tx = 1'b1;
    endcase
  end

endmodule
